// File: rtl/stump_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : stump_mem_arbiter
//  Description : Shares the single Stump memory port between the processor
//                and a DMA/loader requester. The processor always wins and is
//                never stalled. DMA accesses use only processor-idle cycles,
//                with a one-cycle ACK turnaround between DMA grants.
//  Revision    : 1.0  initial release
// ============================================================================
module stump_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 32,
    parameter int WAIT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_wen,
    input  logic              cpu_ren,
    output logic [DATA_W-1:0] cpu_data_in,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_data_in,

    output logic              starve,
    output logic [15:0]       dma_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] c_wait_one = WAIT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                r_starve;
    logic [DATA_W-1:0]   r_rdata;
    logic [15:0]         r_count;

    logic                w_cpu_busy;
    logic                w_dma_go;

    assign w_cpu_busy = cpu_ren | cpu_wen;

    // A DMA grant never lands in the ACK turnaround cycle, and a reset cycle
    // makes no DMA access so an abandoned request cannot touch memory.
    assign w_dma_go = dma_req & ~w_cpu_busy & (r_state != S_ACK) & ~rst;

    // Processor read data is wired straight through: no added latency.
    assign cpu_data_in = mem_data_in;

    assign dma_ack   = (r_state == S_ACK) & ~rst;
    assign dma_rdata = r_rdata;
    assign starve    = r_starve;
    assign dma_count = r_count;

    // Memory port mux: processor first, then a DMA grant, else port idle.
    always_comb begin
        mem_address  = cpu_address;
        mem_data_out = cpu_data_out;
        mem_wen      = 1'b0;
        mem_ren      = 1'b0;
        if (w_cpu_busy) begin
            mem_wen = cpu_wen;
            mem_ren = cpu_ren;
        end else if (w_dma_go) begin
            mem_address  = dma_addr;
            mem_data_out = dma_wdata;
            mem_wen      = dma_we;
            mem_ren      = ~dma_we;
        end
    end

    // Next-state and wait-counter logic for the DMA request tracker.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        case (r_state)
            S_IDLE: begin
                if (w_dma_go) begin
                    w_state_nxt = S_ACK;
                    w_wait_nxt  = '0;
                end else if (dma_req) begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = c_wait_one;
                end
            end
            S_WAIT: begin
                if (w_dma_go) begin
                    w_state_nxt = S_ACK;
                    w_wait_nxt  = '0;
                end else if (!dma_req) begin
                    // Request withdrawn before service: drop it quietly.
                    w_state_nxt = S_IDLE;
                    w_wait_nxt  = '0;
                end else if (r_wait < c_max_wait) begin
                    w_wait_nxt = r_wait + c_wait_one;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
                w_wait_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Read-data capture, sticky starvation flag and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_starve <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_dma_go && !dma_we) begin
                r_rdata <= mem_data_in;
            end
            if (w_wait_nxt == c_max_wait) begin
                r_starve <= 1'b1;
            end
            if (r_state == S_ACK) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
